// File: rtl/pkt_depad_pkg.sv
// Shared types and helpers for the message de-padder: pad marker, FSM states
// and the expected length word derived from the emitted data-word count.
package pkt_depad_pkg;

  // Widest word the helpers support; callers cast down to their own WORD_W.
  localparam int unsigned MAX_W = 128;

  localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    DATA,
    HOLD,
    FLUSH
  } state_e;

  function automatic logic [MAX_W-1:0] pad_word(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

  // Length is in bits and every data word carries 64 of them.
  function automatic logic [MAX_W-1:0] exp_len(input logic [MAX_W-1:0] dcnt);
    return dcnt << 6;
  endfunction

endpackage

// File: rtl/pkt_depad_chk.sv
// End-of-message integrity check: padding seen, block-aligned, length word
// matching the number of data words delivered.
module pkt_depad_chk
  import pkt_depad_pkg::*;
#(
  parameter int unsigned BLK_WORDS = 16,
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned WC_W      = $clog2(BLK_WORDS)
) (
  input  logic              hold_i,
  input  logic [WC_W-1:0]   wcnt_i,
  input  logic [WORD_W-7:0] dcnt_i,
  input  logic [WORD_W-1:0] in_pkt_i,
  output logic              ok_o,
  output logic              err_o
);

  logic [WORD_W-1:0] exp_w;

  assign exp_w = WORD_W'(exp_len(MAX_W'(dcnt_i)));

  // wcnt holds words before the length word, so the block closes at BLK_WORDS-1.
  assign ok_o  = hold_i && (wcnt_i == WC_W'(BLK_WORDS - 1)) && (in_pkt_i == exp_w);
  assign err_o = !ok_o;

endmodule

// File: rtl/pkt_depad.sv
// Receive-side de-padder: strips the trailing marker/zero padding from a
// block stream, forwards data words and reports the recovered message length.
module pkt_depad
  import pkt_depad_pkg::*;
#(
  parameter int unsigned BLK_WORDS = 16,
  parameter int unsigned WORD_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_pkt,
  input  logic              in_vld,
  input  logic              in_last,
  output logic              in_rdy,
  output logic [WORD_W-1:0] out_pkt,
  output logic              out_vld,
  output logic [WORD_W-1:0] msg_len,
  output logic              len_vld,
  output logic              err
);

  localparam int unsigned WC_W = $clog2(BLK_WORDS);
  localparam int unsigned DW   = WORD_W - 6;
  localparam logic [WORD_W-1:0] PAD = WORD_W'(pad_word(WORD_W));

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [WC_W-1:0]   k_q, k_d;
  logic              mark_q, mark_d;
  logic [WORD_W-1:0] out_pkt_q, out_pkt_d;
  logic              out_vld_q, out_vld_d;
  logic [WORD_W-1:0] msg_len_q, msg_len_d;
  logic              len_vld_q, len_vld_d;
  logic              err_q, err_d;
  logic              acc;
  logic              chk_ok, chk_err;

  assign in_rdy  = (state_q != FLUSH);
  assign acc     = in_vld && in_rdy;
  assign out_pkt = out_pkt_q;
  assign out_vld = out_vld_q;
  assign msg_len = msg_len_q;
  assign len_vld = len_vld_q;
  assign err     = err_q;

  pkt_depad_chk #(
    .BLK_WORDS(BLK_WORDS),
    .WORD_W   (WORD_W),
    .WC_W     (WC_W)
  ) u_chk (
    .hold_i  (state_q == HOLD && mark_q),
    .wcnt_i  (wcnt_q),
    .dcnt_i  (dcnt_q),
    .in_pkt_i(in_pkt),
    .ok_o    (chk_ok),
    .err_o   (chk_err)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    dcnt_d    = dcnt_q;
    k_d       = k_q;
    mark_d    = mark_q;
    out_pkt_d = out_pkt_q;
    out_vld_d = 1'b0;
    msg_len_d = msg_len_q;
    len_vld_d = 1'b0;
    err_d     = 1'b0;

    if (acc && in_last) begin
      if (chk_ok) begin
        msg_len_d = in_pkt;
        len_vld_d = 1'b1;
      end
      err_d   = chk_err;
      state_d = DATA;
      wcnt_d  = '0;
      dcnt_d  = '0;
      k_d     = '0;
      mark_d  = 1'b0;
    end else begin
      unique case (state_q)
        DATA: begin
          if (acc) begin
            wcnt_d = wcnt_q + WC_W'(1);
            if (in_pkt == PAD) begin
              state_d = HOLD;
              k_d     = '0;
              mark_d  = 1'b1;
            end else begin
              out_pkt_d = in_pkt;
              out_vld_d = 1'b1;
              dcnt_d    = dcnt_q + DW'(1);
            end
          end
        end
        HOLD: begin
          if (acc) begin
            if (in_pkt == '0 && k_q != WC_W'(BLK_WORDS - 1)) begin
              k_d    = k_q + WC_W'(1);
              wcnt_d = wcnt_q + WC_W'(1);
            end else begin
              // Not consumed: the source keeps presenting it until after the flush.
              state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          out_vld_d = 1'b1;
          dcnt_d    = dcnt_q + DW'(1);
          if (mark_q) begin
            out_pkt_d = PAD;
            mark_d    = 1'b0;
            if (k_q == '0) state_d = DATA;
          end else begin
            out_pkt_d = '0;
            k_d       = k_q - WC_W'(1);
            if (k_q == WC_W'(1)) state_d = DATA;
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DATA;
      wcnt_q    <= '0;
      dcnt_q    <= '0;
      k_q       <= '0;
      mark_q    <= 1'b0;
      out_pkt_q <= '0;
      out_vld_q <= 1'b0;
      msg_len_q <= '0;
      len_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      dcnt_q    <= dcnt_d;
      k_q       <= k_d;
      mark_q    <= mark_d;
      out_pkt_q <= out_pkt_d;
      out_vld_q <= out_vld_d;
      msg_len_q <= msg_len_d;
      len_vld_q <= len_vld_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_pkt_depad.sv
// Self-checking bench for pkt_depad: directed scenarios plus random messages
// compared against a message-level reference model.
module tb_pkt_depad;

  localparam int BLK = 16;
  localparam int W   = 64;
  localparam logic [W-1:0] PAD = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_pkt;
  logic         in_vld;
  logic         in_last;
  logic         in_rdy;
  logic [W-1:0] out_pkt;
  logic         out_vld;
  logic [W-1:0] msg_len;
  logic         len_vld;
  logic         err;

  pkt_depad #(.BLK_WORDS(BLK), .WORD_W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_pkt (in_pkt),
    .in_vld (in_vld),
    .in_last(in_last),
    .in_rdy (in_rdy),
    .out_pkt(out_pkt),
    .out_vld(out_vld),
    .msg_len(msg_len),
    .len_vld(len_vld),
    .err    (err)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] msg_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           low_q[$];
  bit           exp_ok;
  logic [W-1:0] exp_msg_len = '0;
  int           n_len = 0;
  int           n_err = 0;

  always @(negedge clk) begin
    if (out_vld) got_q.push_back(out_pkt);
    if (len_vld) n_len++;
    if (err) n_err++;
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    do w = {$urandom, $urandom}; while (w == '0 || w == PAD);
    return w;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    n_len = 0;
    n_err = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after consumption.
  task automatic send_word(input logic [W-1:0] w, input bit last, output int low);
    int budget;
    bit done;
    low = 0; budget = 0; done = 0;
    in_pkt = w; in_vld = 1'b1; in_last = last;
    while (!done && budget < 64) begin
      while (!in_rdy && budget < 64) begin
        @(negedge clk); low++; budget++;
      end
      if (budget < 64) begin
        @(negedge clk); budget++;
        if (in_rdy) done = 1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: word %h not consumed within 64 cycles", w);
    end
  endtask

  task automatic send_msg(input logic [W-1:0] lenw, input bit gap);
    int low;
    low_q.delete();
    foreach (msg_q[i]) begin
      send_word(msg_q[i], 1'b0, low);
      low_q.push_back(low);
    end
    send_word(lenw, 1'b1, low);
    in_vld = 1'b0; in_last = 1'b0;
    if (gap) repeat (3) @(negedge clk);
  endtask

  // Message-level model: the padding is the last marker followed only by
  // zeros (at most BLK-1 of them); everything before it is delivered data.
  task automatic model(input logic [W-1:0] lenw);
    int n, i, z, keep;
    bit pad_ok;
    n = msg_q.size(); z = 0; i = n - 1;
    while (i >= 0 && msg_q[i] == '0) begin z++; i--; end
    pad_ok = (i >= 0) && (msg_q[i] == PAD) && (z <= BLK - 1);
    keep = pad_ok ? i : n;
    exp_q.delete();
    for (int j = 0; j < keep; j++) exp_q.push_back(msg_q[j]);
    exp_ok = pad_ok && ((n + 1) % BLK == 0) && (lenw == W'(64 * exp_q.size()));
    if (exp_ok) exp_msg_len = lenw;
  endtask

  task automatic build_padded(input int d_words, input int zeros);
    msg_q.delete();
    for (int i = 0; i < d_words; i++) msg_q.push_back(rand_word());
    msg_q.push_back(PAD);
    for (int i = 0; i < zeros; i++) msg_q.push_back('0);
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || len_vld !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b vld=%b len_vld=%b err=%b, need 1 0 0 0", in_rdy, out_vld, len_vld, err);
    end
    n_checks++;
    if (msg_len !== '0 || out_pkt !== '0) begin
      n_fail++;
      $display("FAIL reset_data: msg_len=%h out_pkt=%h, need 0", msg_len, out_pkt);
    end
  endtask

  task automatic test_basic();
    int low;
    clear_obs();
    build_padded(3, 11);
    model(64'd192);
    foreach (msg_q[i]) begin
      send_word(msg_q[i], 1'b0, low);
      if (i == 0) begin
        n_checks++;
        if (out_vld !== 1'b1 || out_pkt !== msg_q[0]) begin
          n_fail++;
          $display("FAIL basic_latency: vld=%b pkt=%h, need 1 %h", out_vld, out_pkt, msg_q[0]);
        end
      end
    end
    send_word(64'd192, 1'b1, low);
    in_vld = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (got_q.size() != 3 || got_q[0] !== msg_q[0] || got_q[1] !== msg_q[1] || got_q[2] !== msg_q[2]) begin
      n_fail++;
      $display("FAIL basic_data: got %0d words, need 3 in order", got_q.size());
    end
    n_checks++;
    if (n_len != 1 || n_err != 0 || msg_len !== 64'd192) begin
      n_fail++;
      $display("FAIL basic_len: len_vld=%0d err=%0d msg_len=%0d, need 1 0 192", n_len, n_err, msg_len);
    end
  endtask

  task automatic test_full_pad();
    clear_obs();
    build_padded(15, 15);
    model(64'd960);
    send_msg(64'd960, 1'b1);
    n_checks++;
    if (got_q != exp_q || got_q.size() != 15) begin
      n_fail++;
      $display("FAIL full_pad_data: got %0d words, need 15", got_q.size());
    end
    n_checks++;
    if (n_len != 1 || n_err != 0 || msg_len !== 64'd960) begin
      n_fail++;
      $display("FAIL full_pad_len: len_vld=%0d err=%0d msg_len=%0d, need 1 0 960", n_len, n_err, msg_len);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] a, b;
    clear_obs();
    a = rand_word(); b = rand_word();
    msg_q = '{a, PAD, '0, '0, b, PAD};
    for (int i = 0; i < 9; i++) msg_q.push_back('0);
    model(64'd320);
    send_msg(64'd320, 1'b1);
    n_checks++;
    if (got_q.size() != 5 || got_q[0] !== a || got_q[1] !== PAD || got_q[2] !== '0 ||
        got_q[3] !== '0 || got_q[4] !== b) begin
      n_fail++;
      $display("FAIL flush_data: got %0d words, need A,marker,0,0,B", got_q.size());
    end
    n_checks++;
    if (low_q[4] != 3) begin
      n_fail++;
      $display("FAIL flush_rdy_low: in_rdy low %0d cycles, need 3", low_q[4]);
    end
    n_checks++;
    if (n_len != 1 || n_err != 0 || msg_len !== 64'd320) begin
      n_fail++;
      $display("FAIL flush_len: len_vld=%0d err=%0d msg_len=%0d, need 1 0 320", n_len, n_err, msg_len);
    end
  endtask

  task automatic test_empty();
    clear_obs();
    build_padded(0, 14);
    model(64'd0);
    send_msg(64'd0, 1'b1);
    n_checks++;
    if (got_q.size() != 0 || n_len != 1 || n_err != 0 || msg_len !== '0) begin
      n_fail++;
      $display("FAIL empty_msg: words=%0d len_vld=%0d err=%0d msg_len=%0d, need 0 1 0 0",
               got_q.size(), n_len, n_err, msg_len);
    end
  endtask

  task automatic test_bad_len();
    logic [W-1:0] prev;
    clear_obs();
    prev = msg_len;
    build_padded(3, 11);
    model(64'd100);
    send_msg(64'd100, 1'b1);
    n_checks++;
    if (n_err != 1 || n_len != 0 || msg_len !== prev || got_q != exp_q) begin
      n_fail++;
      $display("FAIL bad_len: err=%0d len_vld=%0d msg_len=%0d, need 1 0 %0d", n_err, n_len, msg_len, prev);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] both_q[$];
    clear_obs();
    build_padded(3, 7);
    model(64'd192);
    both_q = exp_q;
    send_msg(64'd192, 1'b0);
    build_padded(4, 10);
    model(64'd256);
    both_q = {both_q, exp_q};
    send_msg(64'd256, 1'b1);
    n_checks++;
    if (got_q != both_q) begin
      n_fail++;
      $display("FAIL b2b_data: got %0d words, need %0d", got_q.size(), both_q.size());
    end
    n_checks++;
    if (n_err != 1 || n_len != 1 || msg_len !== 64'd256) begin
      n_fail++;
      $display("FAIL b2b_status: err=%0d len_vld=%0d msg_len=%0d, need 1 1 256", n_err, n_len, msg_len);
    end
  endtask

  task automatic test_reset_mid_hold();
    int low;
    clear_obs();
    send_word(PAD, 1'b0, low);
    for (int i = 0; i < 5; i++) send_word('0, 1'b0, low);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_vld !== 1'b0 || len_vld !== 1'b0 || err !== 1'b0 || msg_len !== '0 || in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: vld=%b len_vld=%b err=%b msg_len=%h rdy=%b, need 0 0 0 0 1",
               out_vld, len_vld, err, msg_len, in_rdy);
    end
    exp_msg_len = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: %0d words after reset, need 0", got_q.size());
    end
    clear_obs();
    build_padded(3, 11);
    model(64'd192);
    send_msg(64'd192, 1'b1);
    n_checks++;
    if (got_q != exp_q || n_len != 1 || n_err != 0 || msg_len !== 64'd192) begin
      n_fail++;
      $display("FAIL after_reset: words=%0d len_vld=%0d err=%0d msg_len=%0d, need 3 1 0 192",
               got_q.size(), n_len, n_err, msg_len);
    end
  endtask

  task automatic test_random();
    int d, z, c, r;
    logic [W-1:0] lenw;
    for (int m = 0; m < 12; m++) begin
      clear_obs();
      msg_q.delete();
      d = $urandom_range(0, 35);
      for (int i = 0; i < d; i++) begin
        r = $urandom_range(0, 7);
        msg_q.push_back(r == 0 ? '0 : (r == 1 ? PAD : rand_word()));
      end
      z = (BLK - ((d + 2) % BLK)) % BLK;
      c = $urandom_range(0, 3);
      if (c == 0) z = (z > 0) ? z - 1 : z + 1;
      msg_q.push_back(PAD);
      for (int i = 0; i < z; i++) msg_q.push_back('0);
      lenw = W'(64 * d) + ((c == 1) ? W'(64) : '0);
      model(lenw);
      send_msg(lenw, 1'b1);
      n_checks++;
      if (got_q != exp_q) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %0d words, need %0d", m, got_q.size(), exp_q.size());
      end
      n_checks++;
      if (n_len != int'(exp_ok) || n_err != int'(!exp_ok) || msg_len !== exp_msg_len) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: len_vld=%0d err=%0d msg_len=%0d, need %0d %0d %0d",
                 m, n_len, n_err, msg_len, exp_ok, !exp_ok, exp_msg_len);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_pkt = '0; in_vld = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_full_pad();
    test_flush();
    test_empty();
    test_bad_len();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_depad.md
Name: pkt_depad

Overview:
- Receive-side counterpart of the message padder.
- Accepts the padded 64-bit word stream: data words, then the pad marker word 0x8000_0000_0000_0000, then zero words, then one message-length word (bits) ending a block.
- Strips the padding, forwards only the data words, and reports the recovered message length.
- Checks padding and alignment integrity; sits between the block stream source and the message consumer.

Parameters:
BLK_WORDS, 16, words per block; power of 2, >= 2
WORD_W, 64, word width; pad marker = 1 << (WORD_W-1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_pkt  input  WORD_W  incoming stream word
in_vld  input  1  in_pkt valid
in_last  input  1  with in_vld: this word is the length word (last of message)
in_rdy  output  1  block can accept; a word is consumed when in_vld & in_rdy
out_pkt  output  WORD_W  recovered data word
out_vld  output  1  out_pkt valid, one-cycle strobe per word; no downstream backpressure
msg_len  output  WORD_W  length word of the finished message, held until next done
len_vld  output  1  one-cycle strobe: message finished with correct padding
err  output  1  one-cycle strobe: message finished with bad padding/length/alignment

Behaviour:
- Reset (async, any state): state=DATA, in_rdy=1, out_vld=0, len_vld=0, err=0, msg_len=0, all counters=0, hold flag=0.
- Counters: wcnt = accepted words mod BLK_WORDS; dcnt = data words emitted in this message (WORD_W-6 bits, wraps); k = held zero words (0..BLK_WORDS-1).
- The pad marker and the zeros after it are not stored; hold = marker flag + k. Releasing regenerates the marker, then k zeros.
- out_pkt/out_vld are registered: a data word appears one cycle after it is accepted.
- States: DATA, HOLD, FLUSH.
- DATA, word accepted, in_last=0:
  - word == marker -> HOLD, k=0, nothing emitted.
  - else -> emit word, dcnt++.
- HOLD, word accepted, in_last=0:
  - zero and k < BLK_WORDS-1 -> k++, nothing emitted.
  - any other word (non-zero, marker, or zero with k == BLK_WORDS-1) -> word NOT consumed, in_rdy=0 from the next cycle, go FLUSH.
- FLUSH:
  - in_rdy=0.
  - Emit marker, then k zeros, one per cycle; dcnt += k+1.
  - Then DATA with in_rdy=1; the pending word is re-presented by the source and processed in DATA.
- in_last word accepted (DATA or HOLD), with total = accepted words including this one:
  - Success requires all of: state HOLD, total mod BLK_WORDS == 0, and in_pkt == {dcnt, 6'b0}.
  - On success: msg_len=in_pkt, len_vld pulses next cycle.
  - On failure: err pulses next cycle and msg_len is unchanged.
  - Either way: counters and hold cleared, state DATA, and the next word starts a new message.
- Held bytes on failure are discarded; no flush is performed.
- Minimality is implied by the k limit: k == BLK_WORDS-1 is the maximum padding run.
- Empty message: marker first, then BLK_WORDS-2 zeros, then length 0 -> no out_vld, len_vld=1.
- in_vld is ignored while in_rdy=0; in_pkt must stay stable from the source.
- Reset asserted mid-HOLD/FLUSH drops held and partial data; no further out_vld until new words arrive.

Decomposition:
- Shared package: PAD_WORD constant, state enum (DATA/HOLD/FLUSH), the function giving the expected length word from dcnt.
- One natural sub-module, pkt_depad_chk: combinational end-of-message check (alignment, hold flag, length compare) -> ok/err.

Test Plan:
- BLK=16, words A,B,C (non-zero, not the marker), marker, 11 zeros, len=192 with in_last -> out A,B,C in order; len_vld=1, msg_len=192, err=0.
- 15 data words, marker at word 15, 15 zeros, len=960 at word 31 -> 15 outputs, no flush, len_vld=1.
- Stream A, marker, 0, 0, B, then valid padding, len=320 -> outputs A,marker,0,0,B.
  - in_rdy low exactly 3 cycles when B is presented.
  - B is emitted after the flush.
- Marker, 14 zeros, len=0 -> no out_vld, len_vld=1, msg_len=0.
- Correct padding but len=100 -> err=1, len_vld=0, msg_len unchanged.
- Length word at word 12 (misaligned) -> err=1.
- Second back-to-back message then decodes cleanly.
- Assert rst during HOLD after 5 zeros -> all outputs 0 immediately.
- A fresh 3-word message afterwards decodes correctly.
